uart_pixel_cmd_parser: RTL and testbench
========================================

Name: uart_pixel_cmd_parser

Overview:
- Sits directly downstream of the UART receiver.
- Consumes its byte stream (one-cycle byte_valid strobe plus byte_data) and assembles fixed-format pixel-write packets.
- Validates each packet and presents the resulting pixel write to the frame-buffer writer over a valid/ready handshake.
- Malformed, out-of-range, timed-out and overrun packets are discarded and counted.

Parameters:
- SYNC_BYTE, 8'hA5, packet start marker.
- H_ACTIVE, 640, x coordinates >= this are rejected.
- V_ACTIVE, 480, y coordinates >= this are rejected.
- COLOR_W, 8, width of the color field; taken from the low bits of the COLOR byte.
- TIMEOUT_CYC, 1_000_000, maximum clk cycles allowed between consecutive bytes of one packet.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- byte_data  in  8  received byte; valid only when byte_valid=1
- byte_valid  in  1  one-cycle strobe per received byte
- wr_valid  out  1  pixel write pending
- wr_ready  in  1  consumer accepts the write when wr_valid & wr_ready
- wr_x  out  10  pixel column
- wr_y  out  9  pixel row
- wr_color  out  COLOR_W  pixel color
- busy  out  1  parser is mid-packet (state != IDLE)
- pkt_err  out  1  one-cycle pulse per discarded packet
- err_cnt  out  8  saturating count of discarded packets

Behaviour:
- Reset: rst_n=0 at a rising edge gives state=IDLE, wr_valid=0, wr_x=0, wr_y=0, wr_color=0, pkt_err=0, err_cnt=0, timeout counter=0, checksum accumulator=0.
  - Applies mid-packet and with a write pending; the pending write is lost, not completed.
- Packet format: SYNC, X_HI, X_LO, Y_HI, Y_LO, COLOR, CHK.
  - CHK = XOR of the five bytes X_HI..COLOR.
- FSM states: IDLE, XH, XL, YH, YL, COL, CHK. A state advances only on a cycle with byte_valid=1.
  - IDLE: a byte equal to SYNC_BYTE moves to XH and clears the accumulator. Any other byte is ignored silently (no error).
  - XH, XL, YH, YL, COL: latch the byte into a 16-bit X, 16-bit Y or color shadow register, XOR it into the accumulator, and advance.
  - CHK: evaluate the packet on the byte's cycle and return to IDLE on the next edge.
- Packet evaluation:
  - Packet is good if accumulator == byte_data, X16 < H_ACTIVE and Y16 < V_ACTIVE. Comparisons use the full 16-bit values, so any nonzero upper bits mean out of range.
  - Good packet with the output slot free (wr_valid=0, or wr_valid & wr_ready in the same cycle): on the next edge load wr_x=X16[9:0], wr_y=Y16[8:0], wr_color=color[COLOR_W-1:0] and set wr_valid=1. Latency is one cycle after the final byte strobe.
  - Good packet with the slot occupied and not draining: discard as overrun.
  - Bad packet: discard.
  - Discard means pkt_err=1 for one cycle and err_cnt+1, saturating at 255.
- Handshake:
  - wr_valid stays high, and wr_x/wr_y/wr_color stay stable, until a cycle with wr_ready=1; wr_valid clears on that edge unless a new packet loads in the same cycle.
  - wr_ready while wr_valid=0 has no effect.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle without byte_valid and resets to 0 on byte_valid.
  - When it reaches TIMEOUT_CYC-1 without a byte: return to IDLE, pulse pkt_err, increment err_cnt.
  - A byte arriving in that same cycle takes priority and no timeout occurs.
- A SYNC_BYTE value appearing mid-packet is treated as ordinary data, with no resync.
- busy = (state != IDLE).

Optional Feature:
- Macro: PIXEL_CMD_CHECKSUM_EN.
- Defined: packets are 7 bytes and the CHK state with the checksum test is present.
- Undefined: packets are 6 bytes (no CHK byte). Evaluation happens on the COLOR byte using only the range and overrun checks; the accumulator logic is not built.

Test Plan:
- Send A5 01 2C 00 F0 E3 with CHK=01^2C^00^F0^E3=3E, wr_ready=1 -> one cycle after the CHK strobe, wr_valid=1 with wr_x=300, wr_y=240, wr_color=E3; it clears after one cycle; err_cnt=0.
- Same packet with CHK=3F -> no wr_valid; pkt_err pulses once; err_cnt=1; busy=0 afterwards.
- X=0x0280 (640) with a correct checksum -> rejected; err_cnt increments. X=0x027F, Y=0x01DF with a correct checksum -> accepted with wr_x=639, wr_y=479.
- Two good packets back-to-back with wr_ready=0 -> first is held stable with wr_valid=1; second is discarded with err_cnt=1. Raising wr_ready then drops wr_valid after one cycle.
- Send A5 01 then nothing for TIMEOUT_CYC cycles (set to 100 in the bench) -> pkt_err pulse, state IDLE; a following valid packet is accepted normally.
- Reset (rst_n=0 for one edge) while wr_valid=1 and mid-packet -> all outputs 0, state IDLE; bytes 11 22 A5 then a valid packet produce exactly one write.

Source files
------------

// File: rtl/uart_pixel_cmd_parser_if.sv
// Byte-in / pixel-write-out bundle for uart_pixel_cmd_parser.
// master = parser side, slave = UART/frame-buffer side.
interface uart_pixel_cmd_parser_if #(
  parameter int COLOR_W = 8
);
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               wr_valid;
  logic               wr_ready;
  logic [9:0]         wr_x;
  logic [8:0]         wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               busy;
  logic               pkt_err;
  logic [7:0]         err_cnt;

  modport master (
    input  byte_data,
    input  byte_valid,
    input  wr_ready,
    output wr_valid,
    output wr_x,
    output wr_y,
    output wr_color,
    output busy,
    output pkt_err,
    output err_cnt
  );

  modport slave (
    output byte_data,
    output byte_valid,
    output wr_ready,
    input  wr_valid,
    input  wr_x,
    input  wr_y,
    input  wr_color,
    input  busy,
    input  pkt_err,
    input  err_cnt
  );
endinterface

// File: rtl/uart_pixel_cmd_parser.sv
// Assembles UART bytes into validated pixel writes.
// Define PIXEL_CMD_CHECKSUM_EN for 7-byte packets with XOR checksum.
module uart_pixel_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         H_ACTIVE    = 640,
  parameter int         V_ACTIVE    = 480,
  parameter int         COLOR_W     = 8,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input logic                     clk,
  input logic                     rst_n,
  uart_pixel_cmd_parser_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    XH,
    XL,
    YH,
    YL,
`ifdef PIXEL_CMD_CHECKSUM_EN
    COL,
    CHK
`else
    COL
`endif
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [15:0]        x16;
  logic [15:0]        y16;
  logic [TW-1:0]      tcnt;
  logic               timeout;
  logic               last;
  logic               eval;
  logic               chk_ok;
  logic               range_ok;
  logic               slot_free;
  logic               load;
  logic               drop;
  logic [COLOR_W-1:0] color_eval;

`ifdef PIXEL_CMD_CHECKSUM_EN
  logic [7:0]         color_q;
  logic [7:0]         acc;

  assign last       = (state == CHK);
  assign chk_ok     = (acc == bus.byte_data);
  assign color_eval = color_q[COLOR_W-1:0];
`else
  assign last       = (state == COL);
  assign chk_ok     = 1'b1;
  assign color_eval = bus.byte_data[COLOR_W-1:0];
`endif

  assign timeout   = (state != IDLE) && !bus.byte_valid
                  && (tcnt == T_LAST);
  assign eval      = last && bus.byte_valid;
  assign range_ok  = (x16 < 16'(H_ACTIVE))
                  && (y16 < 16'(V_ACTIVE));
  assign slot_free = !bus.wr_valid || bus.wr_ready;
  assign load      = eval && chk_ok && range_ok && slot_free;
  // overrun, bad checksum and range failures all land here
  assign drop      = (eval && !load) || timeout;
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bus.byte_valid && bus.byte_data == SYNC_BYTE)
          nxt = XH;
      XH: if (bus.byte_valid) nxt = XL;
      XL: if (bus.byte_valid) nxt = YH;
      YH: if (bus.byte_valid) nxt = YL;
      YL: if (bus.byte_valid) nxt = COL;
`ifdef PIXEL_CMD_CHECKSUM_EN
      COL: if (bus.byte_valid) nxt = CHK;
      CHK: if (bus.byte_valid) nxt = IDLE;
`else
      COL: if (bus.byte_valid) nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
    if (timeout) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x16  <= '0;
      y16  <= '0;
      tcnt <= '0;
`ifdef PIXEL_CMD_CHECKSUM_EN
      color_q <= '0;
      acc     <= '0;
`endif
    end else begin
      if (state == IDLE || bus.byte_valid || timeout)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);
      if (bus.byte_valid) begin
        unique case (state)
          XH: x16[15:8] <= bus.byte_data;
          XL: x16[7:0]  <= bus.byte_data;
          YH: y16[15:8] <= bus.byte_data;
          YL: y16[7:0]  <= bus.byte_data;
`ifdef PIXEL_CMD_CHECKSUM_EN
          COL: color_q  <= bus.byte_data;
`endif
          default: ;
        endcase
      end
`ifdef PIXEL_CMD_CHECKSUM_EN
      if (bus.byte_valid) begin
        if (state == IDLE && bus.byte_data == SYNC_BYTE)
          acc <= '0;
        else if (state != IDLE && state != CHK)
          acc <= acc ^ bus.byte_data;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wr_valid <= 1'b0;
      bus.wr_x     <= '0;
      bus.wr_y     <= '0;
      bus.wr_color <= '0;
      bus.pkt_err  <= 1'b0;
      bus.err_cnt  <= '0;
    end else begin
      if (load) begin
        bus.wr_valid <= 1'b1;
        bus.wr_x     <= x16[9:0];
        bus.wr_y     <= y16[8:0];
        bus.wr_color <= color_eval;
      end else if (bus.wr_ready) begin
        bus.wr_valid <= 1'b0;
      end
      bus.pkt_err <= drop;
      if (drop && bus.err_cnt != 8'hFF)
        bus.err_cnt <= bus.err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_pixel_cmd_parser.sv
// Scoreboard bench for uart_pixel_cmd_parser.
// Follows PIXEL_CMD_CHECKSUM_EN to pick 6- or 7-byte packets.
module tb_uart_pixel_cmd_parser;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] c;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr = 0;
  int   n_perr = 0;
  int   exp_err = 0;
  int   exp_perr = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  uart_pixel_cmd_parser_if #(.COLOR_W(8)) bus();

  uart_pixel_cmd_parser #(
    .TIMEOUT_CYC(100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] x,
                          input logic [15:0] y,
                          input logic [7:0] c);
`ifdef PIXEL_CMD_CHECKSUM_EN
    logic [7:0] k;
    k = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ c;
`endif
    send_byte(8'hA5);
    send_byte(x[15:8]);
    send_byte(x[7:0]);
    send_byte(y[15:8]);
    send_byte(y[7:0]);
    send_byte(c);
`ifdef PIXEL_CMD_CHECKSUM_EN
    send_byte(k);
`endif
  endtask

  task automatic check_errs(input string name);
    check({name, "_cnt"}, bus.err_cnt, exp_err);
    check({name, "_pulses"}, n_perr, exp_perr);
  endtask

  // monitor: pop the scoreboard on every accepted write
  initial begin
    wr_t  got;
    wr_t  prev;
    wr_t  want;
    logic pv;
    logic pr;
    pv   = 1'b0;
    pr   = 1'b0;
    got  = '0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.pkt_err) n_perr++;
      if (rst_n && bus.wr_valid) begin
        got = {bus.wr_x, bus.wr_y, bus.wr_color};
        if (pv && !pr) check("hold_stable", got, prev);
        if (bus.wr_ready) begin
          n_wr++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got %0h want none",
                     got);
          end else begin
            want = exp_q.pop_front();
            check("write", got, want);
          end
        end
        prev = got;
      end
      pv = rst_n && bus.wr_valid;
      pr = bus.wr_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.wr_ready   = 1'b0;
    repeat (2) tick();
    check("rst_valid", bus.wr_valid, 0);
    check("rst_x", bus.wr_x, 0);
    check("rst_y", bus.wr_y, 0);
    check("rst_color", bus.wr_color, 0);
    check("rst_perr", bus.pkt_err, 0);
    check("rst_errcnt", bus.err_cnt, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // basic good packet, consumer ready
    bus.wr_ready = 1'b1;
    exp_q.push_back({10'd300, 9'd240, 8'hE3});
    send_pkt(16'h012C, 16'h00F0, 8'hE3);
    check("lat_valid", bus.wr_valid, 1);
    check("lat_x", bus.wr_x, 300);
    tick();
    check("valid_clear", bus.wr_valid, 0);
    check_errs("good");

`ifdef PIXEL_CMD_CHECKSUM_EN
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h2C);
    send_byte(8'h00);
    send_byte(8'hF0);
    send_byte(8'hE3);
    send_byte(8'h3F);
    exp_err++;
    exp_perr++;
    check("badchk_valid", bus.wr_valid, 0);
    tick();
    check("badchk_busy", bus.busy, 0);
    check_errs("badchk");
`endif

    // range boundaries
    send_pkt(16'h0280, 16'h0000, 8'h11);
    exp_err++;
    exp_perr++;
    tick();
    check("x640_valid", bus.wr_valid, 0);
    check_errs("x640");
    exp_q.push_back({10'd639, 9'd479, 8'h5A});
    send_pkt(16'h027F, 16'h01DF, 8'h5A);
    check("edge_valid", bus.wr_valid, 1);
    tick();

    // overrun while the slot is held
    bus.wr_ready = 1'b0;
    exp_q.push_back({10'd10, 9'd20, 8'h33});
    send_pkt(16'd10, 16'd20, 8'h33);
    send_pkt(16'd30, 16'd40, 8'h44);
    exp_err++;
    exp_perr++;
    repeat (3) tick();
    check("hold_valid", bus.wr_valid, 1);
    check("hold_x", bus.wr_x, 10);
    check_errs("overrun");
    bus.wr_ready = 1'b1;
    tick();
    check("drain_clear", bus.wr_valid, 0);

    // inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (90) tick();
    check("to_busy_early", bus.busy, 1);
    for (int i = 0; i < 50 && bus.busy; i++) tick();
    check("to_busy_after", bus.busy, 0);
    exp_err++;
    exp_perr++;
    tick();
    check_errs("timeout");
    exp_q.push_back({10'd5, 9'd6, 8'h77});
    send_pkt(16'd5, 16'd6, 8'h77);
    repeat (2) tick();

    // reset with a pending write and a packet in flight
    bus.wr_ready = 1'b0;
    send_pkt(16'd1, 16'd2, 8'h99);
    send_byte(8'hA5);
    send_byte(8'h01);
    check("pre_rst_valid", bus.wr_valid, 1);
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    check("mrst_valid", bus.wr_valid, 0);
    check("mrst_x", bus.wr_x, 0);
    check("mrst_y", bus.wr_y, 0);
    check("mrst_color", bus.wr_color, 0);
    check("mrst_perr", bus.pkt_err, 0);
    check("mrst_errcnt", bus.err_cnt, 0);
    check("mrst_busy", bus.busy, 0);
    rst_n = 1'b1;
    exp_err = 0;
    bus.wr_ready = 1'b1;
    n0 = n_wr;
    send_byte(8'h11);
    send_byte(8'h22);
    exp_q.push_back({10'd100, 9'd200, 8'hC4});
    send_pkt(16'd100, 16'd200, 8'hC4);
    repeat (3) tick();
    check("post_rst_writes", n_wr - n0, 1);
    check("post_rst_errs", bus.err_cnt, exp_err);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
